// File: rtl/soc_led_pwm_fader.sv
// soc_led_pwm_fader: turns the on/off LED pattern from the PIO into PWM drive.
// When a bit changes, its brightness ramps toward full or dark by STEP once per
// PWM period instead of jumping there. A bypass input shows the registered
// pattern directly for debug.
module soc_led_pwm_fader #(
  parameter int NUM_LEDS = 10,
  parameter int PWM_BITS = 8,
  parameter int CLK_DIV  = 196,
  parameter int STEP     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic                bypass,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [NUM_LEDS-1:0] fading
);

  // A one-bit prescaler is kept for CLK_DIV=1. It then sits at 0, and 0 is
  // also its terminal count, so a tick occurs on every cycle.
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  // The fade arithmetic carries one spare bit so that overflow and underflow
  // can be seen before saturation.
  localparam logic [PWM_BITS:0]   MAX_W    = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP);

  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level     [NUM_LEDS];
  logic [PWM_BITS-1:0] level_nxt [NUM_LEDS];
  logic [PWM_BITS:0]   up_w      [NUM_LEDS];
  logic [PWM_BITS:0]   dn_w      [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_in_q;
  logic [NUM_LEDS-1:0] led_nxt;
  logic [NUM_LEDS-1:0] fading_nxt;
  logic                tick;
  logic                period_end;

  assign tick       = (prescaler == PRE_LAST);
  assign period_end = tick && (pwm_cnt == MAX);

  // Shared timebase: the prescaler divides clk into PWM ticks, and pwm_cnt
  // counts ticks and wraps from MAX to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else if (tick) begin
      prescaler <= '0;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Per-channel next level (saturating step toward the target), PWM compare
  // and fade-status flag.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      up_w[i]       = {1'b0, level[i]} + STEP_W;
      // When level < STEP, the wrap sets the spare top bit. That bit marks an
      // underflow.
      dn_w[i]       = {1'b0, level[i]} - STEP_W;
      level_nxt[i]  = level[i];
      led_nxt[i]    = 1'b0;
      fading_nxt[i] = 1'b0;
      if (led_in_q[i]) begin
        level_nxt[i]  = (up_w[i] > MAX_W) ? MAX : up_w[i][PWM_BITS-1:0];
        fading_nxt[i] = (level[i] != MAX);
      end else begin
        level_nxt[i]  = dn_w[i][PWM_BITS] ? '0 : dn_w[i][PWM_BITS-1:0];
        fading_nxt[i] = (level[i] != '0);
      end
      if (bypass) begin
        led_nxt[i] = led_in_q[i];
      end else if (level[i] == MAX) begin
        led_nxt[i] = 1'b1;
      end else if (level[i] == '0) begin
        led_nxt[i] = 1'b0;
      end else begin
        led_nxt[i] = (pwm_cnt < level[i]);
      end
    end
  end

  // Input capture, level updates at period boundaries and registered outputs.
  // The fade keeps running during bypass, so releasing bypass shows the real
  // current level.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_in_q <= '0;
      led_out  <= '0;
      fading   <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
      end
    end else begin
      led_in_q <= led_in;
      led_out  <= led_nxt;
      fading   <= fading_nxt;
      if (period_end) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          level[i] <= level_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_led_pwm_fader.sv
// Bench for soc_led_pwm_fader (10 LEDs, 4-bit PWM, tick every clk, step 4).
module tb_soc_led_pwm_fader;

  localparam int NL  = 10;
  localparam int PB  = 4;
  localparam int CD  = 1;
  localparam int ST  = 4;
  localparam int MX  = (1 << PB) - 1;
  localparam int PER = CD * (MX + 1);

  logic          clk;
  logic          reset;
  logic [NL-1:0] led_in;
  logic          bypass;
  logic [NL-1:0] led_out;
  logic [NL-1:0] fading;

  soc_led_pwm_fader #(
    .NUM_LEDS (NL),
    .PWM_BITS (PB),
    .CLK_DIV  (CD),
    .STEP     (ST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .led_in  (led_in),
    .bypass  (bypass),
    .led_out (led_out),
    .fading  (fading)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and check ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model works at the behavioural level. A cycle count since reset gives
  // the PWM phase. Each brightness value is an integer that moves by STEP at
  // period ends and is clamped to 0..MX.
  int            m_n;
  int            m_lvl [NL];
  logic [NL-1:0] m_lq;
  logic [19:0]   exp_q[$];   // {fading, led_out} expected after each edge
  int            mark_q[$];  // -1 reset, 1 last output of a PWM period, 0 otherwise

  task automatic model_step();
    int            pwm;
    int            tgt;
    logic [NL-1:0] e_led;
    logic [NL-1:0] e_fad;
    if (reset) begin
      m_n  = 0;
      m_lq = '0;
      for (int i = 0; i < NL; i++) m_lvl[i] = 0;
      exp_q.push_back('0);
      mark_q.push_back(-1);
    end else begin
      pwm = (m_n / CD) % (MX + 1);
      for (int i = 0; i < NL; i++) begin
        tgt      = m_lq[i] ? MX : 0;
        e_fad[i] = (m_lvl[i] != tgt);
        if (bypass)            e_led[i] = m_lq[i];
        else if (m_lvl[i] == MX) e_led[i] = 1'b1;
        else                   e_led[i] = (pwm < m_lvl[i]);
      end
      if ((m_n + 1) % PER == 0) begin
        for (int i = 0; i < NL; i++) begin
          tgt = m_lq[i] ? MX : 0;
          if (m_lvl[i] < tgt)      m_lvl[i] = (m_lvl[i] + ST > MX) ? MX : m_lvl[i] + ST;
          else if (m_lvl[i] > tgt) m_lvl[i] = (m_lvl[i] - ST < 0) ? 0 : m_lvl[i] - ST;
        end
      end
      mark_q.push_back(((m_n + 1) % PER == 0) ? 1 : 0);
      exp_q.push_back({e_fad, e_led});
      m_n++;
      m_lq = led_in;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  int hi_cnt = 0;
  int hc_q[$];   // measured led_out[0] high count per PWM period

  initial forever begin
    logic [19:0] e;
    int          mk;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      mk = mark_q.pop_front();
      check("cycle", {fading, led_out}, e);
      if (mk < 0) begin
        hi_cnt = 0;
      end else begin
        if (led_out[0]) hi_cnt++;
        if (mk == 1) begin
          hc_q.push_back(hi_cnt);
          hi_cnt = 0;
        end
      end
    end
  end

  task automatic check_seq(input string tag, input int idx0, input int skip, input int want[4]);
    int i;
    i = idx0;
    while (i < hc_q.size() && hc_q[i] == skip) i++;
    for (int k = 0; k < 4; k++) begin
      check(tag, (i + k < hc_q.size()) ? 20'(hc_q[i + k]) : 20'hFFFFF, 20'(want[k]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NL-1:0] led, input logic byp);
    @(posedge clk);
    #2;
    led_in = led;
    bypass = byp;
  endtask

  task automatic wait_level(input int ch, input int v, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (m_lvl[ch] == v) break;
    end
    check("wait_lvl", 20'(m_lvl[ch]), 20'(v));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx0;
    reset  = 1'b1;
    led_in = '0;
    bypass = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // idle: everything dark
    for (int k = 0; k < 5; k++) begin
      repeat (20) @(negedge clk);
      check("idle", {fading, led_out}, '0);
    end

    // fade up on channel 0
    idx0 = hc_q.size();
    drive(10'h001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("fading_on", 20'(fading), 20'h00001);
    wait_level(0, MX, 200);
    repeat (2 * PER) @(posedge clk);
    check_seq("rise", idx0, 0, '{4, 8, 12, 16});
    @(negedge clk);
    check("fading_off", 20'(fading), 20'h0);
    check("others_dark", 20'(led_out & 10'h3FE), 20'h0);

    // fade down
    idx0 = hc_q.size();
    drive(10'h000, 1'b0);
    wait_level(0, 0, 200);
    repeat (2 * PER) @(posedge clk);
    check_seq("fall", idx0, 16, '{11, 7, 3, 0});
    @(negedge clk);
    check("fading_down_off", 20'(fading), 20'h0);

    // reversal mid-period at level 8
    idx0 = hc_q.size();
    drive(10'h001, 1'b0);
    wait_level(0, 8, 200);
    repeat (5) @(posedge clk);
    #2 led_in = 10'h000;
    wait_level(0, 0, 200);
    repeat (2 * PER) @(posedge clk);
    check_seq("reverse", idx0, 0, '{4, 8, 4, 0});

    // bypass, then release with all levels at full
    drive(10'h3FF, 1'b0);
    wait_level(9, MX, 300);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (m_n % PER == 1) break;
    end
    led_in = 10'h2A5;
    bypass = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bypass", 20'(led_out), 20'h002A5);
    bypass = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release", 20'(led_out), 20'h003FF);

    // reset mid-fade at level 8, then restart from 0
    drive(10'h000, 1'b0);
    wait_level(0, 0, 200);
    drive(10'h001, 1'b0);
    wait_level(0, 8, 200);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_mid", {fading, led_out}, '0);
    idx0 = hc_q.size();
    repeat (6 * PER) @(posedge clk);
    check_seq("restart", idx0, 0, '{4, 8, 12, 16});

    // randomized patterns, bypass and occasional reset
    for (int r = 0; r < 60; r++) begin
      drive(NL'($urandom_range(0, 1023)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
      end
      repeat ($urandom_range(1, 60)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
